// File: rtl/tick_monitor.sv
// tick_monitor: measures tick_in rising-edge spacing and tracks lock/fault; clk, rst, tick_in, clear -> period, period_valid, locked, fault, err_count
module tick_monitor #(
  parameter int EXPECTED_PERIOD = 50000000,
  parameter int TOLERANCE = 16,
  parameter int LOCK_COUNT = 4,
  localparam int TIMEOUT = 2 * EXPECTED_PERIOD,
  localparam int W = $clog2(TIMEOUT + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick_in,
  input  logic         clear,
  output logic [W-1:0] period,
  output logic         period_valid,
  output logic         locked,
  output logic         fault,
  output logic [7:0]   err_count
);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [W-1:0] TMAX = W'(TIMEOUT);
  localparam logic [W:0] WLO = (W+1)'(EXPECTED_PERIOD - TOLERANCE);
  localparam logic [W:0] WHI = (W+1)'(EXPECTED_PERIOD + TOLERANCE);
  localparam logic [GW-1:0] GMAX = GW'(LOCK_COUNT);
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, FAULT} state_t;
  state_t state, state_n;
  logic tick_q, ev, tmo, in_win, meas, err_inc;
  logic [W-1:0] timer, timer_n;
  logic [GW-1:0] good, good_n;
  assign ev = tick_in & ~tick_q;
  assign tmo = timer == TMAX;
  assign in_win = {1'b0, timer} >= WLO && {1'b0, timer} <= WHI;
  assign meas = ev && !tmo && state != IDLE;
  always_comb begin
    state_n = state;
    good_n = good;
    err_inc = 1'b0;
    timer_n = ev ? W'(1) : state == IDLE ? '0 : tmo ? TMAX : timer + 1'b1;
    case (state)
      IDLE: if (ev) begin
        state_n = ACQUIRE;
        good_n = '0;
      end
      ACQUIRE: if (ev && in_win) begin
        good_n = good + 1'b1;
        state_n = good + 1'b1 == GMAX ? LOCKED : ACQUIRE;
      end else if (ev || tmo) begin
        good_n = '0;
        err_inc = 1'b1;
        state_n = ev ? ACQUIRE : FAULT;
      end
      LOCKED: if (ev ? !in_win : tmo) begin
        state_n = FAULT;
        err_inc = 1'b1;
      end
      FAULT: if (ev) begin
        state_n = ACQUIRE;
        good_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      good <= '0;
      tick_q <= 1'b0;
      period <= '0;
      period_valid <= 1'b0;
      locked <= 1'b0;
      fault <= 1'b0;
      err_count <= '0;
    end else begin
      tick_q <= tick_in;
      if (clear) begin
        state <= IDLE;
        timer <= '0;
        good <= '0;
        period_valid <= 1'b0;
        locked <= 1'b0;
        fault <= 1'b0;
        err_count <= '0;
      end else begin
        state <= state_n;
        timer <= timer_n;
        good <= good_n;
        period_valid <= meas;
        if (meas) period <= timer;
        locked <= state_n == LOCKED;
        fault <= state_n == FAULT;
        if (err_inc && err_count != 8'hff) err_count <= err_count + 1'b1;
      end
    end
  end
endmodule
